// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-level UART transmitter.
// Build option: UART_TX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

    localparam int unsigned UART_DATA_W          = 8;
    localparam int unsigned UART_DIV_W           = 16;
    localparam int unsigned UART_BIT_CNT_W       = 3;
    localparam int unsigned UART_DEFAULT_CLK_DIV = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// Held at zero while clear_i is high so every frame starts on a fresh bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = UART_DEFAULT_CLK_DIV
)
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic bit_tick_c_o
);

    logic [UART_DIV_W-1:0] r_cnt;

    assign bit_tick_c_o = !clear_i && (r_cnt == UART_DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clear_i || bit_tick_c_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + UART_DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter with a ready/start handshake and a frame-done pulse.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit(s).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = UART_DEFAULT_CLK_DIV,
    parameter int unsigned STOP_BITS = 1
)
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [UART_DATA_W-1:0] tx_byte_i,
    input  logic                   tx_start_i,
    output logic                   tx_o,
    output logic                   ready_o,
    output logic                   is_transmitting_o,
    output logic                   done_o
);

    uart_state_e                r_state;
    logic [UART_DATA_W-1:0]     r_shift;
    logic [UART_BIT_CNT_W-1:0]  r_bit_cnt;
    logic                       r_tx;
    logic                       r_ready;
    logic                       r_busy;
    logic                       r_done;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    logic                       w_baud_clear;
    logic                       w_bit_tick;
    logic                       w_accept;
    logic [UART_DATA_W-1:0]     w_shift_nxt;

    assign w_baud_clear = (r_state == ST_IDLE);
    assign w_accept     = tx_start_i && r_ready;
    assign w_shift_nxt  = r_shift >> 1;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (w_baud_clear),
        .bit_tick_c_o (w_bit_tick)
    );

    // Frame sequencer; every state change lands on a bit tick except IDLE->START.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_shift   <= tx_byte_i;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^tx_byte_i;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == UART_BIT_CNT_W'(UART_DATA_W - 1)) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= ST_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= ST_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_shift   <= w_shift_nxt;
                            r_tx      <= w_shift_nxt[0];
                            r_bit_cnt <= r_bit_cnt + UART_BIT_CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                // Bit counter is reused to count stop-bit periods.
                ST_STOP: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == UART_BIT_CNT_W'(STOP_BITS - 1)) begin
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= '0;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + UART_BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o              = r_tx;
    assign ready_o           = r_ready;
    assign is_transmitting_o = r_busy;
    assign done_o            = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames,
// a negedge monitor reassembles each frame from tx_o and compares it.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB0 = 10 + PAR;   // bits per frame, one stop bit
    localparam int NB1 = 11 + PAR;   // bits per frame, two stop bits

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte0, byte1;
    logic       start0, start1;
    logic       tx0, rdy0, busy0, done0;
    logic       tx1, rdy1, busy1, done1;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(DIV), .STOP_BITS(1)) u_dut0 (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .tx_byte_i         (byte0),
        .tx_start_i        (start0),
        .tx_o              (tx0),
        .ready_o           (rdy0),
        .is_transmitting_o (busy0),
        .done_o            (done0)
    );

    uart_tx_serializer #(.CLK_DIV(DIV), .STOP_BITS(2)) u_dut1 (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .tx_byte_i         (byte1),
        .tx_start_i        (start1),
        .tx_o              (tx1),
        .ready_o           (rdy1),
        .is_transmitting_o (busy1),
        .done_o            (done1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] expq0[$];
    logic [11:0] expq1[$];

    logic        in_frame [2];
    int          k        [2];
    int          err_tx   [2];
    int          err_busy [2];
    int          err_side [2];
    logic [11:0] cur      [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line image of one frame, bit 0 first on the wire; unused upper bits stay idle-high.
    function automatic logic [11:0] make_frame(input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic mon_step(input int id, input logic tx, input logic busy,
                            input logic done, input logic rdy, input int nb);
        if (!in_frame[id]) begin
            if (tx === 1'b0) begin
                if (id == 0 && expq0.size() > 0) begin
                    cur[id] = expq0.pop_front();
                end else if (id == 1 && expq1.size() > 0) begin
                    cur[id] = expq1.pop_front();
                end else begin
                    chk($sformatf("dut%0d_unexpected_frame", id), 32'd1, 32'd0);
                    cur[id] = '1;
                end
                in_frame[id] = 1'b1;
                k[id]        = 0;
                err_tx[id]   = 0;
                err_busy[id] = 0;
                err_side[id] = 0;
            end else begin
                chk($sformatf("dut%0d_idle_no_done", id), 32'(done), 32'd0);
            end
        end
        if (in_frame[id]) begin
            if (k[id] < nb * int'(DIV)) begin
                if (tx !== cur[id][k[id] / int'(DIV)]) err_tx[id]++;
                if (busy !== 1'b1) err_busy[id]++;
                if (done !== 1'b0 || rdy !== 1'b0) err_side[id]++;
                k[id]++;
            end else begin
                chk($sformatf("dut%0d_frame_%03h_bit_errors", id, cur[id]), 32'(err_tx[id]), 32'd0);
                chk($sformatf("dut%0d_busy_low_in_frame", id), 32'(err_busy[id]), 32'd0);
                chk($sformatf("dut%0d_ready_or_done_in_frame", id), 32'(err_side[id]), 32'd0);
                chk($sformatf("dut%0d_done_at_frame_end", id), 32'(done), 32'd1);
                chk($sformatf("dut%0d_busy_fell_at_end", id), 32'(busy), 32'd0);
                chk($sformatf("dut%0d_ready_at_end", id), 32'(rdy), 32'd1);
                chk($sformatf("dut%0d_tx_high_at_end", id), 32'(tx), 32'd1);
                in_frame[id] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame[0] = 1'b0;
            in_frame[1] = 1'b0;
        end else begin
            mon_step(0, tx0, busy0, done0, rdy0, NB0);
            mon_step(1, tx1, busy1, done1, rdy1, NB1);
        end
    end

    task automatic send(input int id, input logic [7:0] d);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (((id == 0) ? rdy0 : rdy1) !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("send_ready_timeout", 32'd1, 32'd0);
        if (id == 0) begin
            byte0 = d; start0 = 1'b1; expq0.push_back(make_frame(d));
        end else begin
            byte1 = d; start1 = 1'b1; expq1.push_back(make_frame(d));
        end
        @(posedge clk); #1;
        if (id == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_done(input int id);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((id == 0) ? done0 : done1) !== 1'b1 && guard < 200);
        if (guard >= 200) chk($sformatf("dut%0d_done_timeout", id), 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        byte0  = 8'h00; byte1 = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_tx", 32'(tx0), 32'd1);
        chk("reset_ready", 32'(rdy0), 32'd1);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_tx_dut1", 32'(tx1), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // basic 8N1 frame
        send(0, 8'hA5);
        wait_done(0);
        repeat (3) @(posedge clk);

        // back-to-back with start held high, next byte presented on the done cycle
        @(posedge clk); #1;
        byte0 = 8'h00; start0 = 1'b1; expq0.push_back(make_frame(8'h00));
        wait_done(0);
        byte0 = 8'hFF; expq0.push_back(make_frame(8'hFF));
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        chk("b2b_start_bit_immediate", 32'(tx0), 32'd0);
        wait_done(0);
        repeat (3) @(posedge clk);

        // start while busy is ignored
        send(0, 8'h81);
        repeat (10) @(posedge clk);
        #1 byte0 = 8'h3C; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("ready_low_while_busy", 32'(rdy0), 32'd0);
        wait_done(0);
        repeat (12) @(posedge clk);

        // reset during DATA bit 3 aborts the frame without a clock
        send(0, 8'h55);
        repeat (17) @(negedge clk);
        chk("pre_reset_data_bit3_low", 32'(tx0), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_tx_high", 32'(tx0), 32'd1);
        chk("async_reset_ready", 32'(rdy0), 32'd1);
        chk("async_reset_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 8'h55);
        wait_done(0);
        repeat (3) @(posedge clk);

        // two stop bits
        send(1, 8'h01);
        wait_done(1);
        repeat (3) @(posedge clk);

        // parity-sensitive bytes (even parity 0 and 1 when enabled)
        send(0, 8'hA5);
        wait_done(0);
        send(0, 8'h07);
        wait_done(0);

        repeat (6) @(negedge clk);
        chk("dut0_scoreboard_drained", 32'(expq0.size()), 32'd0);
        chk("dut1_scoreboard_drained", 32'(expq1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
